// File: rtl/fir_decim_halfband_2x.sv
// fir_decim_halfband_2x
//   Stereo 2:1 decimating half-band FIR (11 taps, symmetric, odd taps zero).
//   Every accepted input strobe shifts both delay lines. Every second accepted
//   strobe starts one computation. Each channel has one time-shared multiplier
//   that works through the three symmetric pairs. The centre tap (0.5) is then
//   added, the sum is rounded half-up to 18 bits and the result is limited.
//
//   Configuration macro: FIR_DECIM_SATURATE_EN
//     defined   -> rounded result is clamped to [-131072, 131071]
//     undefined -> rounded result wraps (18 LSBs kept)
//
//   Parameters: H0, H2, H4  signed Q1.17 coefficients for taps 0/10, 2/8, 4/6
//   Ports:
//     clk                        system clock, rising edge
//     reset                      asynchronous reset, active low
//     sample_in_rdy              one-cycle strobe, input sample valid
//     sample_in_l, sample_in_r   signed 18-bit input samples
//     sample_out_rdy             one-cycle strobe, output sample valid
//     sample_out_l, sample_out_r signed 18-bit decimated samples (held)
//     busy                       computation in progress, strobes are dropped
//     overrun                    one-cycle pulse, an input strobe was dropped
module fir_decim_halfband_2x #(
    parameter int H0 = 1638,
    parameter int H2 = -8192,
    parameter int H4 = 39322
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_in_rdy,
    input  logic signed [17:0] sample_in_l,
    input  logic signed [17:0] sample_in_r,
    output logic               sample_out_rdy,
    output logic signed [17:0] sample_out_l,
    output logic signed [17:0] sample_out_r,
    output logic               busy,
    output logic               overrun
);

    localparam int DW   = 18;  // sample / coefficient width
    localparam int PW   = 19;  // pre-add width
    localparam int MW   = 37;  // product width
    localparam int AW   = 40;  // accumulator width
    localparam int Taps = 11;
    localparam int NCh  = 2;   // 0 = left, 1 = right

    localparam logic signed [DW-1:0] Coef0     = DW'(H0);
    localparam logic signed [DW-1:0] Coef2     = DW'(H2);
    localparam logic signed [DW-1:0] Coef4     = DW'(H4);
    localparam logic signed [AW-1:0] RoundBias = AW'(65536);
`ifdef FIR_DECIM_SATURATE_EN
    localparam logic signed [AW-1:0] SatMax    = AW'(131071);
    localparam logic signed [AW-1:0] SatMin    = AW'(-131072);
    localparam logic signed [DW-1:0] OutMax    = 18'sh1FFFF;
    localparam logic signed [DW-1:0] OutMin    = 18'sh20000;
`endif

    typedef enum logic [2:0] {StIdle, StMac0, StMac1, StMac2, StRound} state_e;

    state_e state_q, state_d;

    logic busy_q, phase_q, fin_q, rdy_q, overrun_q;
    logic accept, trigger;

    logic [1:0] mac_sel;
    logic       prod_en, acc_load, acc_add, round_en;

    logic signed [DW-1:0] dl_q      [NCh][Taps];
    logic signed [DW-1:0] in_s      [NCh];
    logic signed [DW-1:0] coef;
    logic signed [PW-1:0] pre       [NCh];
    logic signed [MW-1:0] prod_d    [NCh];
    logic signed [MW-1:0] prod_q    [NCh];
    logic signed [AW-1:0] center    [NCh];
    logic signed [AW-1:0] round_sum [NCh];
    logic signed [AW-1:0] acc_q     [NCh];
    logic signed [DW-1:0] out_lim   [NCh];
    logic signed [DW-1:0] out_q     [NCh];

    always_comb begin
        in_s[0] = sample_in_l;
        in_s[1] = sample_in_r;
    end

    // Strobes arriving while busy are dropped without touching line or phase.
    assign accept  = sample_in_rdy & ~busy_q;
    assign trigger = accept & phase_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trigger) state_d = StMac0;
            StMac0:  state_d = StMac1;
            StMac1:  state_d = StMac2;
            StMac2:  state_d = StRound;
            StRound: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Multiplier output is registered, so each state accumulates the product
    // launched by the previous state.
    always_comb begin
        mac_sel  = 2'd0;
        prod_en  = 1'b0;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        round_en = 1'b0;
        unique case (state_q)
            StIdle:  begin end
            StMac0:  begin mac_sel = 2'd0; prod_en = 1'b1; end
            StMac1:  begin mac_sel = 2'd1; prod_en = 1'b1; acc_load = 1'b1; end
            StMac2:  begin mac_sel = 2'd2; prod_en = 1'b1; acc_add  = 1'b1; end
            StRound: begin round_en = 1'b1; end
            default: begin end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        unique case (mac_sel)
            2'd1:    coef = Coef2;
            2'd2:    coef = Coef4;
            default: coef = Coef0;
        endcase
    end

    always_comb begin
        for (int ch = 0; ch < NCh; ch++) begin
            pre[ch] = '0;
            unique case (mac_sel)
                2'd1:    pre[ch] = PW'(dl_q[ch][2]) + PW'(dl_q[ch][8]);
                2'd2:    pre[ch] = PW'(dl_q[ch][4]) + PW'(dl_q[ch][6]);
                default: pre[ch] = PW'(dl_q[ch][0]) + PW'(dl_q[ch][10]);
            endcase
            prod_d[ch]    = MW'(pre[ch]) * MW'(coef);
            // Centre tap is exactly 0.5 in Q1.17: a shift, no multiplier.
            center[ch]    = AW'(dl_q[ch][5]) <<< 16;
            round_sum[ch] = (acc_q[ch] + AW'(prod_q[ch]) + center[ch] + RoundBias) >>> 17;
        end
    end

    // After StRound the accumulator holds the rounded value; limit it here.
    always_comb begin
        for (int ch = 0; ch < NCh; ch++) begin
`ifdef FIR_DECIM_SATURATE_EN
            if (acc_q[ch] > SatMax) begin
                out_lim[ch] = OutMax;
            end else if (acc_q[ch] < SatMin) begin
                out_lim[ch] = OutMin;
            end else begin
                out_lim[ch] = acc_q[ch][DW-1:0];
            end
`else
            out_lim[ch] = acc_q[ch][DW-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NCh; ch++) begin
                for (int t = 0; t < Taps; t++) begin
                    dl_q[ch][t] <= '0;
                end
            end
        end else if (accept) begin
            for (int ch = 0; ch < NCh; ch++) begin
                dl_q[ch][0] <= in_s[ch];
                for (int t = 1; t < Taps; t++) begin
                    dl_q[ch][t] <= dl_q[ch][t-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NCh; ch++) begin
                prod_q[ch] <= '0;
                acc_q[ch]  <= '0;
                out_q[ch]  <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCh; ch++) begin
                if (prod_en) begin
                    prod_q[ch] <= prod_d[ch];
                end
                if (acc_load) begin
                    acc_q[ch] <= AW'(prod_q[ch]);
                end else if (acc_add) begin
                    acc_q[ch] <= acc_q[ch] + AW'(prod_q[ch]);
                end else if (round_en) begin
                    acc_q[ch] <= round_sum[ch];
                end
                if (fin_q) begin
                    out_q[ch] <= out_lim[ch];
                end
            end
        end
    end

    // ------------------------------------------------------------ control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            phase_q   <= 1'b0;
            fin_q     <= 1'b0;
            rdy_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (trigger) begin
                busy_q <= 1'b1;
            end else if (fin_q) begin
                busy_q <= 1'b0;
            end
            if (accept) begin
                phase_q <= ~phase_q;
            end
            fin_q     <= round_en;
            rdy_q     <= fin_q;
            overrun_q <= sample_in_rdy & busy_q;
        end
    end

    assign sample_out_rdy = rdy_q;
    assign sample_out_l   = out_q[0];
    assign sample_out_r   = out_q[1];
    assign busy           = busy_q;
    assign overrun        = overrun_q;

endmodule
